recip_cordic_arbiter: RTL and testbench
=======================================

Name: recip_cordic_arbiter

Overview:
Round-robin arbiter and sequencer that shares one iterative reciprocal CORDIC core among NUM_REQ requesters. It accepts one operand at a time over valid/ready, issues the core's one-cycle enable, and holds the core input stable for the whole computation. It captures the core result on the core's valid pulse and returns it tagged with the requester ID over a valid/ready response channel. It sits between the per-channel normalisation logic and the single reciprocal core instance.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WORD_LENGTH, 18, operand/result width, signed fixed point, must match core
FRAC_LENGTH, 11, fractional bits; used only for bypass constant and test values
ID_W, $clog2(NUM_REQ), width of rsp_id (localparam)

Ports:
CLK  in  1  clock
RST  in  1  reset
req_valid  in  NUM_REQ  per-requester operand valid
req_data  in  NUM_REQ*WORD_LENGTH  operands; requester i at bits [i*WORD_LENGTH +: WORD_LENGTH]
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
rsp_valid  out  1  result valid
rsp_data  out  WORD_LENGTH  reciprocal result
rsp_id  out  ID_W  index of requester that owns rsp_data
rsp_ready  in  1  downstream accepts result
core_enable  out  1  one-cycle start pulse to core
core_input  out  WORD_LENGTH  operand to core
core_result  in  WORD_LENGTH  core reciprocal output
core_valid  in  1  core done pulse
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: reset RST, asynchronous, active-low; clock CLK. Core shares the same CLK/RST.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, core_enable=0, core_input=0, busy=0, rr_ptr=0, state=IDLE.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant]=1 combinationally; all other bits 0. req_ready is 0 in every other state.
  - A transfer occurs when req_valid&req_ready. On transfer: latch the operand into core_input, latch grant into id_reg, set rr_ptr=(grant+1) mod NUM_REQ, go to LAUNCH.
  - No request pending: stay in IDLE, rr_ptr unchanged.
- LAUNCH: core_enable=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - core_input is held constant; the core reads its input combinationally at completion.
  - On core_valid=1: register rsp_data=core_result and rsp_id=id_reg, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_valid&rsp_ready.
  - On handshake: rsp_valid=0 next cycle, go to IDLE. The next grant can be accepted in that IDLE cycle.
- core_valid outside WAIT is ignored. A core_valid in the same cycle as core_enable is ignored.
- Latency, accept to rsp_valid: 2 + core latency. With the default 11-iteration core (valid 13 cycles after enable), rsp_valid rises 15 cycles after the accept edge.
- Throughput: one operation in flight. New requests are blocked (req_ready=0) until the response handshake completes.
- Requester dropping req_valid before grant: no transfer, no state change.
- Reset asserted mid-operation (any state): immediate return to reset values. The in-flight result is discarded and the pointer returns to 0.
- No arithmetic is performed on data paths. core_result is passed through bit-exact.

Optional Feature:
RECIP_ARB_ZERO_BYPASS_EN
- Defined:
  - In IDLE, an accepted operand equal to 0 skips LAUNCH/WAIT; core_enable is not pulsed.
  - Go directly to RESP with rsp_data = most-positive value ({1'b0,{(WORD_LENGTH-1){1'b1}}}, 0x1FFFF at default width) and rsp_id = grant.
  - rsp_valid rises 1 cycle after accept.
- Undefined: a zero operand is sent to the core like any other value, and the core's result is returned unchanged.

Test Plan:
- Single request: req 0 data 0x00800 (1.0) -> one core_enable pulse; rsp_valid 15 cycles later; rsp_id=0; rsp_data=0x00800 ±2 LSB; req_ready low throughout.
- All four requesters valid simultaneously, operands 0x00800/0x01000/0x00400/0x02000, rsp_ready=1 -> service order IDs 0,1,2,3. Results ≈0x00800/0x00400/0x01000/0x00200.
- Fairness: req 1 and req 3 held valid continuously after req 1 granted -> grants alternate 3,1,3,1; rr_ptr wraps 3->0 correctly.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable, busy=1, no req_ready. Release -> handshake, IDLE next cycle.
- RST low during WAIT -> all outputs at reset values next edge. Spurious core_valid afterwards in IDLE produces no rsp_valid.
- Zero operand: with RECIP_ARB_ZERO_BYPASS_EN, rsp_data=0x1FFFF one cycle after accept and no core_enable. Without it, core_enable pulses and core_result is returned.

Source files
------------

// File: rtl/recip_cordic_arbiter.sv
// Purpose : round-robin share of one iterative reciprocal CORDIC core among NUM_REQ requesters.
// Latency : accept -> rsp_valid = 2 + core latency (15 cycles with the 11-iteration core).
// Backpres: one operation in flight; req_ready stays low until the response handshake completes.
//
// Ports:
//   CLK, RST            clock, asynchronous active-low reset (shared with the core)
//   req_valid/req_data  per-requester operand offer; requester i at [i*WORD_LENGTH +: WORD_LENGTH]
//   req_ready           one-hot (or zero) accept, only while idle
//   rsp_valid/rsp_data/rsp_id/rsp_ready  tagged result channel, held stable until taken
//   core_enable         one-cycle start pulse to the core
//   core_input          operand to the core, held for the whole computation
//   core_result/core_valid  core output and its done pulse
//   busy                high whenever an operation or response is outstanding
//
// Build option: define RECIP_ARB_ZERO_BYPASS_EN to answer a zero operand with the most-positive
// value one cycle after accept, without starting the core.
module recip_cordic_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WORD_LENGTH = 18,
    parameter int FRAC_LENGTH = 11,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rsp_valid,
    output logic [WORD_LENGTH-1:0]         rsp_data,
    output logic [ID_W-1:0]                rsp_id,
    input  logic                           rsp_ready,
    output logic                           core_enable,
    output logic [WORD_LENGTH-1:0]         core_input,
    input  logic [WORD_LENGTH-1:0]         core_result,
    input  logic                           core_valid,
    output logic                           busy
);

    // Saturated reciprocal returned for a zero operand when the bypass is built in.
    localparam logic [WORD_LENGTH-1:0] MAX_POS = {1'b0, {(WORD_LENGTH-1){1'b1}}};

    // Reject configurations the datapath cannot represent.
    if (NUM_REQ < 2 || FRAC_LENGTH >= WORD_LENGTH) begin : g_bad_cfg
        $error("recip_cordic_arbiter: invalid NUM_REQ/FRAC_LENGTH configuration");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [WORD_LENGTH-1:0] core_input_q, core_input_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [WORD_LENGTH-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]        rsp_id_q, rsp_id_d;

    logic                   grant_vld;
    logic [ID_W-1:0]        grant_idx;
    logic [ID_W-1:0]        grant_next;
    logic [WORD_LENGTH-1:0] grant_dat;
    logic                   zero_bypass;

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int cand;
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(cand);
            end
        end
    end

    assign grant_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    assign grant_dat  = req_data[grant_idx*WORD_LENGTH +: WORD_LENGTH];

`ifdef RECIP_ARB_ZERO_BYPASS_EN
    assign zero_bypass = (grant_dat == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        core_input_d = core_input_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        req_ready    = '0;
        core_enable  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // req_ready is raised only for the winner, so a grant is a transfer.
                if (grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    core_input_d         = grant_dat;
                    id_d                 = grant_idx;
                    rr_ptr_d             = grant_next;
                    if (zero_bypass) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = MAX_POS;
                        rsp_id_d    = grant_idx;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                // core_valid here is ignored: it cannot belong to this operation.
                core_enable = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (core_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = core_result;
                    rsp_id_d    = id_q;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            core_input_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            core_input_q <= core_input_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign core_input = core_input_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_recip_cordic_arbiter.sv
// Bench for recip_cordic_arbiter: a 13-cycle reciprocal core model, directed scenarios and a
// randomized phase, all compared each cycle against a flag/counter reference model.
module tb_recip_cordic_arbiter;
    localparam int N = 4;
    localparam int W = 18;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_id;
    logic           rsp_ready;
    logic           core_enable;
    logic [W-1:0]   core_input;
    logic [W-1:0]   core_result;
    logic           core_valid;
    logic           busy;

    logic           cm_valid, spur_valid;
    logic [W-1:0]   cm_result, spur_data;
    assign core_valid  = cm_valid | spur_valid;
    assign core_result = spur_valid ? spur_data : cm_result;

    recip_cordic_arbiter #(.NUM_REQ(N), .WORD_LENGTH(W), .FRAC_LENGTH(11)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
        .core_enable(core_enable), .core_input(core_input),
        .core_result(core_result), .core_valid(core_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int en_count = 0;
    int grant_log[$];
    int grant_cyc[$];
    int rise_cyc[$];
    int rsp_id_log[$];
    logic [W-1:0] rsp_data_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ideal Q6.11 reciprocal, saturated; the modelled core answers 0x2AAAA for a zero operand.
    function automatic logic [W-1:0] recip_ideal(input logic [W-1:0] x);
        int xi, q;
        if (x == '0) return 18'h2AAAA;
        xi = int'($signed(x));
        q  = (1 << 22) / xi;
        if (q > 131071)  q = 131071;
        if (q < -131072) q = -131072;
        return W'(q);
    endfunction

    function automatic bit near(input logic [W-1:0] a, input int ideal);
        int d;
        d = int'($signed(a)) - ideal;
        return (d >= -2) && (d <= 2);
    endfunction

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Core model: samples the enable before the edge, raises valid for the cycle sampled
    // 13 edges after the enable edge, with up to +-2 LSB of CORDIC error.
    initial begin
        int cnt;
        int r;
        logic en_s;
        logic [W-1:0] in_s, op;
        cm_valid = 1'b0;
        cm_result = '0;
        cnt = 0;
        op = '0;
        forever begin
            @(negedge CLK);
            en_s = core_enable;
            in_s = core_input;
            @(posedge CLK);
            #1;
            cm_valid = 1'b0;
            if (!RST) begin
                cnt = 0;
            end else if (en_s) begin
                cnt = 12;
                op  = in_s;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    cm_valid = 1'b1;
                    if (op == '0) begin
                        cm_result = recip_ideal(op);
                    end else begin
                        r = int'($signed(recip_ideal(op))) + int'($urandom_range(4, 0)) - 2;
                        if (r > 131071)  r = 131071;
                        if (r < -131072) r = -131072;
                        cm_result = W'(r);
                    end
                end
            end
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        bit in_op, waiting, rsp_v, byp, hs, prev_rv;
        int k_cnt, rr, cur_id, rsp_i, g, c;
        logic [W-1:0] last_in, rsp_d;
        logic [N-1:0] exp_rdy;
        in_op = 0; waiting = 0; rsp_v = 0; byp = 0; prev_rv = 0;
        k_cnt = 0; rr = 0; cur_id = 0; rsp_i = 0; last_in = '0; rsp_d = '0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST) begin
                chk("rst_req_ready", 32'(req_ready), 0);
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_rsp_data", 32'(rsp_data), 0);
                chk("rst_rsp_id", 32'(rsp_id), 0);
                chk("rst_core_enable", 32'(core_enable), 0);
                chk("rst_core_input", 32'(core_input), 0);
                chk("rst_busy", 32'(busy), 0);
                in_op = 0; waiting = 0; rsp_v = 0; byp = 0; prev_rv = 0;
                k_cnt = 0; rr = 0; last_in = '0;
            end else begin
                exp_rdy = '0;
                g = -1;
                if (!in_op) begin
                    for (int k = 0; k < N; k++) begin
                        c = (rr + k) % N;
                        if (g < 0 && req_valid[c]) g = c;
                    end
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                chk("busy", 32'(busy), 32'(in_op));
                chk("core_enable", 32'(core_enable), 32'(in_op && k_cnt == 1 && !byp));
                chk("core_input", 32'(core_input), 32'(last_in));
                chk("rsp_valid", 32'(rsp_valid), 32'(rsp_v));
                if (rsp_v) begin
                    chk("rsp_data", 32'(rsp_data), 32'(rsp_d));
                    chk("rsp_id", 32'(rsp_id), 32'(rsp_i));
                end
                if (core_enable) en_count++;
                if (g >= 0) begin
                    grant_log.push_back(g);
                    grant_cyc.push_back(cyc);
                end
                if (rsp_valid && !prev_rv) rise_cyc.push_back(cyc);
                prev_rv = rsp_valid;
                if (rsp_valid && rsp_ready) begin
                    rsp_id_log.push_back(int'(rsp_id));
                    rsp_data_log.push_back(rsp_data);
                end
                // Advance to the state after the coming edge.
                hs = rsp_v && rsp_ready;
                if (!in_op) begin
                    if (g >= 0) begin
                        last_in = req_data[g*W +: W];
                        cur_id  = g;
                        rr      = (g + 1) % N;
                        in_op   = 1;
                        k_cnt   = 1;
`ifdef RECIP_ARB_ZERO_BYPASS_EN
                        if (last_in == '0) begin
                            byp = 1; waiting = 0; rsp_v = 1; rsp_d = 18'h1FFFF; rsp_i = g;
                        end else begin
                            byp = 0; waiting = 1;
                        end
`else
                        byp = 0; waiting = 1;
`endif
                    end
                end else begin
                    if (waiting && k_cnt >= 2 && core_valid) begin
                        rsp_v = 1; rsp_d = core_result; rsp_i = cur_id; waiting = 0;
                    end
                    k_cnt++;
                    if (hs) begin
                        rsp_v = 0;
                        in_op = 0;
                    end
                end
            end
        end
    end

    // Offer operands on the masked lanes, dropping each lane once it is accepted.
    task automatic send(input logic [N-1:0] mask, input logic [N*W-1:0] data, input int budget);
        logic [N-1:0] pend, taken;
        int t;
        pend = mask;
        t = 0;
        @(posedge CLK); #1;
        req_data  = data;
        req_valid = pend;
        while (pend != '0 && t < budget) begin
            @(negedge CLK);
            taken = req_valid & req_ready;
            @(posedge CLK); #1;
            pend = pend & ~taken;
            req_valid = pend;
            t++;
        end
        req_valid = '0;
        chk("send_accepted", 32'(pend), 0);
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int t;
        t = 0;
        while (rsp_id_log.size() < n && t < budget) begin
            @(negedge CLK);
            t++;
        end
        chk("rsp_arrived", 32'(rsp_id_log.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        @(negedge CLK);
        while ((busy || rsp_valid) && t < budget) begin
            @(negedge CLK);
            t++;
        end
        chk("idle_reached", 32'(busy), 0);
    endtask

    task automatic apply_reset();
        @(posedge CLK); #3;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gb, rb, eb, cb;
        logic [N*W-1:0] rd;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        spur_valid = 1'b0;
        spur_data  = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;

        // Single request, 1.0 -> 1.0, 15-cycle latency, one enable.
        gb = grant_log.size(); rb = rsp_id_log.size(); eb = en_count; cb = rise_cyc.size();
        send(4'b0001, pack4(18'h00800, 18'h0, 18'h0, 18'h0), 5);
        wait_rsp(rb + 1, 40);
        chk("t1_id", 32'(rsp_id_log[rb]), 0);
        chk("t1_data_near", 32'(near(rsp_data_log[rb], 2048)), 1);
        chk("t1_latency", 32'(rise_cyc[cb] - grant_cyc[gb]), 15);
        chk("t1_enables", 32'(en_count - eb), 1);
        wait_idle(20);

        // All four at once from reset: service order 0,1,2,3.
        apply_reset();
        rb = rsp_id_log.size();
        send(4'b1111, pack4(18'h00800, 18'h01000, 18'h00400, 18'h02000), 200);
        wait_rsp(rb + 4, 100);
        chk("t2_id0", 32'(rsp_id_log[rb]), 0);
        chk("t2_id1", 32'(rsp_id_log[rb+1]), 1);
        chk("t2_id2", 32'(rsp_id_log[rb+2]), 2);
        chk("t2_id3", 32'(rsp_id_log[rb+3]), 3);
        chk("t2_d0", 32'(near(rsp_data_log[rb], 2048)), 1);
        chk("t2_d1", 32'(near(rsp_data_log[rb+1], 1024)), 1);
        chk("t2_d2", 32'(near(rsp_data_log[rb+2], 4096)), 1);
        chk("t2_d3", 32'(near(rsp_data_log[rb+3], 512)), 1);
        wait_idle(20);

        // Fairness: 1 then 1 and 3 held -> 3,1,3,1.
        gb = grant_log.size();
        send(4'b0010, pack4(18'h0, 18'h00800, 18'h0, 18'h01000), 5);
        req_data  = pack4(18'h0, 18'h00800, 18'h0, 18'h01000);
        req_valid = 4'b1010;
        begin
            int t;
            t = 0;
            while (grant_log.size() < gb + 5 && t < 200) begin
                @(negedge CLK);
                t++;
            end
        end
        @(posedge CLK); #1;
        req_valid = '0;
        chk("t3_g0", 32'(grant_log[gb]), 1);
        chk("t3_g1", 32'(grant_log[gb+1]), 3);
        chk("t3_g2", 32'(grant_log[gb+2]), 1);
        chk("t3_g3", 32'(grant_log[gb+3]), 3);
        chk("t3_g4", 32'(grant_log[gb+4]), 1);
        wait_idle(40);

        // Backpressure: hold the response 10 cycles, then release.
        rsp_ready = 1'b0;
        rb = rsp_id_log.size();
        send(4'b0100, pack4(18'h0, 18'h0, 18'h00C00, 18'h0), 5);
        begin
            int t;
            t = 0;
            while (!rsp_valid && t < 40) begin
                @(negedge CLK);
                t++;
            end
        end
        repeat (10) begin
            @(negedge CLK);
            chk("t4_busy_held", 32'(busy), 1);
            chk("t4_valid_held", 32'(rsp_valid), 1);
        end
        @(posedge CLK); #1;
        rsp_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("t4_busy_after", 32'(busy), 0);
        chk("t4_valid_after", 32'(rsp_valid), 0);
        chk("t4_data_near", 32'(near(rsp_data_log[rb], 1365)), 1);
        chk("t4_id", 32'(rsp_id_log[rb]), 2);

        // Reset during WAIT, then a spurious core_valid while idle.
        send(4'b0010, pack4(18'h0, 18'h00800, 18'h0, 18'h0), 5);
        repeat (5) @(posedge CLK);
        #2;
        RST = 1'b0;
        @(negedge CLK);
        chk("t5_busy_rst", 32'(busy), 0);
        chk("t5_core_input_rst", 32'(core_input), 0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        spur_valid = 1'b1;
        spur_data  = 18'h12345;
        @(posedge CLK); #1;
        spur_valid = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("t5_no_spurious_rsp", 32'(rsp_valid), 0);
        end
        gb = grant_log.size();
        send(4'b0110, pack4(18'h0, 18'h00800, 18'h00400, 18'h0), 60);
        chk("t5_rr_reset", 32'(grant_log[gb]), 1);
        wait_idle(40);

        // Zero operand.
        gb = grant_log.size(); rb = rsp_id_log.size(); eb = en_count; cb = rise_cyc.size();
        send(4'b0100, pack4(18'h0, 18'h0, 18'h0, 18'h0), 5);
        wait_rsp(rb + 1, 40);
        chk("t6_id", 32'(rsp_id_log[rb]), 2);
`ifdef RECIP_ARB_ZERO_BYPASS_EN
        chk("t6_data", 32'(rsp_data_log[rb]), 32'h1FFFF);
        chk("t6_latency", 32'(rise_cyc[cb] - grant_cyc[gb]), 1);
        chk("t6_enables", 32'(en_count - eb), 0);
`else
        chk("t6_data", 32'(rsp_data_log[rb]), 32'h2AAAA);
        chk("t6_latency", 32'(rise_cyc[cb] - grant_cyc[gb]), 15);
        chk("t6_enables", 32'(en_count - eb), 1);
`endif
        wait_idle(20);

        // Randomized traffic with random downstream backpressure.
        rb = rsp_id_log.size();
        repeat (3000) begin
            @(posedge CLK); #1;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(9, 0) < 3);
                rd[i*W +: W] = ($urandom_range(7, 0) == 0) ? '0 : W'($urandom());
            end
            req_data  = rd;
            rsp_ready = ($urandom_range(9, 0) < 7);
        end
        @(posedge CLK); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle(40);
        chk("rand_progress", 32'(rsp_id_log.size() - rb > 50), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
